// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions used by the transmit path.
package uart_tx_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous read port.
module uart_tx_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PtrW-1:0] waddr,
  input  uart_byte_t      wdata,
  input  logic [PtrW-1:0] raddr,
  output uart_byte_t      rdata
);

  uart_byte_t mem_q [DEPTH];

  // Storage is deliberately not reset; only the FIFO control state is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of uart_tx: first-word-fall-through head on tx_data, sticky overflow flag.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  uart_byte_t               wr_data,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     tx_req,
  output uart_byte_t               tx_data,
  input  logic                     tx_ready
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, drop;

  assign tx_req      = (level_q != '0);
  assign full        = (level_q == LevelW'(DEPTH));
  assign almost_full = (level_q >= LevelW'(ALMOST_FULL));
  assign level       = level_q;
  assign overflow    = overflow_q;

  // A pop in the same cycle frees the slot, so a write at full is still taken.
  assign pop  = tx_ready && tx_req;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      level_d = level_q + LevelW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LevelW'(1);
    end
    // A drop in the same cycle as a clear must not be lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  uart_tx_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(tx_data)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, ALMOST_FULL=12).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH      (16),
    .ALMOST_FULL(12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; tx_ready = 1'b0; clr_overflow = 1'b0; reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_byte;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    idle();
    chk("rst_level", level, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);

    // Two consecutive writes, then drain with tx_ready pulses.
    wr_en = 1'b1; wr_data = 8'h48; tick();
    chk("w1_level", level, 1);
    chk("w1_tx_data", tx_data, 8'h48);
    wr_data = 8'h69; tick(); idle();
    chk("w2_level", level, 2);
    chk("w2_tx_req", tx_req, 1);
    chk("w2_tx_data", tx_data, 8'h48);
    tick();
    chk("hold_tx_data", tx_data, 8'h48);
    tx_ready = 1'b1; tick(); idle();
    chk("p1_tx_data", tx_data, 8'h69);
    chk("p1_level", level, 1);
    tx_ready = 1'b1; tick(); idle();
    chk("p2_tx_req", tx_req, 0);
    chk("p2_level", level, 0);

    // tx_ready while empty is ignored.
    tx_ready = 1'b1; tick(); idle();
    chk("empty_pop_level", level, 0);
    chk("empty_pop_tx_req", tx_req, 0);
    wr_en = 1'b1; wr_data = 8'h31; tick(); idle();
    chk("after_empty_tx_data", tx_data, 8'h31);
    chk("after_empty_level", level, 1);
    tx_ready = 1'b1; tick(); idle();
    chk("drain31_level", level, 0);

    // Fill with 0x00..0x0F; pointers start at 3 so the wrap is exercised.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
      chk("fill_level", level, i + 1);
      chk("fill_almost_full", almost_full, (i + 1) >= 12);
      chk("fill_full", full, (i + 1) == 16);
      chk("fill_head", tx_data, 8'h00);
    end
    idle();

    // Write at full without pop is dropped.
    wr_en = 1'b1; wr_data = 8'hAA; tick(); idle();
    chk("drop_level", level, 16);
    chk("drop_overflow", overflow, 1);
    chk("drop_head", tx_data, 8'h00);

    // Push and pop together at full.
    wr_en = 1'b1; wr_data = 8'h55; tx_ready = 1'b1; tick(); idle();
    chk("pushpop_level", level, 16);
    chk("pushpop_full", full, 1);
    chk("pushpop_head", tx_data, 8'h01);

    for (int i = 0; i < 16; i++) begin
      exp_byte = (i < 15) ? 8'(i + 1) : 8'h55;
      chk("drain_data", tx_data, exp_byte);
      tx_ready = 1'b1; tick(); idle();
    end
    chk("drain_tx_req", tx_req, 0);
    chk("drain_overflow_sticky", overflow, 1);

    clr_overflow = 1'b1; tick(); idle();
    chk("clr_overflow", overflow, 0);

    // Overflow set wins over a simultaneous clear.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i); tick();
    end
    chk("refill_full", full, 1);
    wr_en = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1; tick(); idle();
    chk("set_wins_overflow", overflow, 1);
    chk("set_wins_level", level, 16);

    // Reset mid-operation discards queue and flag.
    reset = 1'b1; tick(); idle();
    chk("midrst_level", level, 0);
    chk("midrst_tx_req", tx_req, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_full", full, 0);

    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
    end
    idle();
    chk("five_level", level, 5);
    chk("five_head", tx_data, 8'h10);
    reset = 1'b1; tick(); idle();
    chk("rst5_level", level, 0);
    chk("rst5_tx_req", tx_req, 0);
    chk("rst5_overflow", overflow, 0);

    // Pointers restart at 0 after reset.
    wr_en = 1'b1; wr_data = 8'h7E; tick(); idle();
    chk("post_rst_head", tx_data, 8'h7E);
    chk("post_rst_level", level, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of `uart_tx`: it accepts bytes from a producer (CPU register, message sequencer) at clock rate and drains them into the transmitter using its `tx_req`/`tx_data`/`tx_ready` handshake. It decouples bursty writers from the slow serial line and reports fill level and overflow. Synchronous single-clock design; storage is a small register array.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `ALMOST_FULL`, 12: `almost_full` asserts when `level >= ALMOST_FULL`; range 1..DEPTH.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe; one byte per cycle high.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  `level == DEPTH`.
- `almost_full`  out  1  `level >= ALMOST_FULL`.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.
- `clr_overflow`  in  1  clears `overflow`.
- `tx_req`  out  1  to `uart_tx.tx_req`; high whenever FIFO not empty.
- `tx_data`  out  8  to `uart_tx.tx_data`; head-of-queue byte.
- `tx_ready`  in  1  from `uart_tx.tx_ready`; one-cycle pulse = head byte consumed.

## Operation
- State: `wr_ptr`, `rd_ptr` ($clog2(DEPTH) bits, wrap modulo DEPTH), `level` counter, `overflow` flag, memory array.
- Write accepted when `wr_en && (!full || pop)`, where `pop = tx_ready && tx_req`. Accepted write: `mem[wr_ptr] <= wr_data`, `wr_ptr` +1.
- Write with `full && !pop`: byte dropped, no pointer/level change, `overflow <= 1`.
- Pop: `rd_ptr` +1. `tx_ready` while empty is ignored (no pointer/level change).
- Level: +1 on push-only, −1 on pop-only, unchanged on push+pop or neither.
- Simultaneous push and pop at full: both performed, stays full. At empty, `tx_ready` cannot be valid (tx_req low), so push only.
- `tx_req = (level != 0)`; `tx_data = mem[rd_ptr]` (asynchronous read, first-word-fall-through). `tx_data` must stay constant while `tx_req` high until the pop cycle; only `rd_ptr` moves it.
- `overflow` priority: set event wins over `clr_overflow` in same cycle.
- Pointer wrap: DEPTH is power of two, natural binary rollover; full/empty determined solely from `level`.
- Memory contents are not reset; only control state.

## Timing
- Reset (synchronous): `wr_ptr=0`, `rd_ptr=0`, `level=0`, `overflow=0` → `tx_req=0`, `full=0`, `almost_full=0`, `tx_data` undefined (don't-care while `tx_req=0`).
- Reset asserted mid-operation: queue discarded in one cycle; a byte already captured by `uart_tx` still transmits (downstream owns it).
- Write latency: `wr_en` at cycle N → `level`, `tx_req`, `tx_data` updated at N+1.
- Pop latency: `tx_ready` at cycle M → next byte on `tx_data` (or `tx_req` low if level was 1) at M+1.
- `uart_tx` samples `tx_data` on a baud tick and pulses `tx_ready` one cycle later; FIFO holds `tx_data` stable across that gap, never advancing without `tx_ready`.
- Full throughput on write side: one byte/cycle until full.

## Structure
- Shared UART package: `UART_DATA_W = 8`; FIFO uses it for `wr_data`/`tx_data`.
- Pointer width `$clog2(DEPTH)` and level width derived locally as localparams.
- One sub-module natural: `fifo_mem` (DEPTH×8 register array, one sync write port, one async read port), so it can be swapped for a RAM primitive.
- Top instantiates `uart_tx_fifo` feeding `uart_tx`.

## Test plan
- Reset, then write 0x48,0x69 in consecutive cycles → `level`=2, `tx_req`=1, `tx_data`=0x48; pulse `tx_ready` → `tx_data`=0x69, `level`=1; pulse again → `tx_req`=0.
- Write 16 bytes 0x00..0x0F (DEPTH=16) → `full`=1 and `almost_full`=1 from 12th byte's next cycle; 17th write 0xAA → dropped, `overflow`=1, `level`=16; drain → bytes 0x00..0x0F in order.
- At full, `wr_en` with 0x55 and `tx_ready` same cycle → `level` stays 16, 0x55 emerges last after draining.
- `tx_ready` pulse while empty → `level`=0, pointers unchanged; next write 0x31 appears on `tx_data` next cycle.
- Connected to `uart_tx` (MAIN_CLK=100 MHz, BAUD=115200): write "Hello" → serial line shows 5 frames, start bit 0, LSB-first, stop bit 1, bytes 0x48 0x65 0x6C 0x6C 0x6F.
- Fill 5 bytes, assert `reset` one cycle → `level`=0, `tx_req`=0, `overflow`=0; `overflow` set then `clr_overflow` with simultaneous overflow event → `overflow` stays 1.
